trigger_out_async: RTL and testbench
====================================

# trigger_out_async

Transmit-side counterpart of the asynchronous trigger receiver. It takes a trigger request from the clk80 domain, tagged with a 4-bit fine position in clk400 units. It then drives a single trigger pulse on an output pin, placed at that position within the next sync frame, with 2.5 ns resolution and a programmable width. The block sits between the trigger sequencer (clk80 logic) and the trigger output pad.

## Interface
Parameters:
- LOAD_SLOT, 7: slot at which the clk80-captured request is moved into the clk400 pending register; must be smaller than the frame length in clk400 cycles.

Ports:
- clk400  in  1  400 MHz clock; reset reset, asynchronous, active-high; clock clk400
- reset  in  1  asynchronous, active-high, clears every register in both domains
- clk80  in  1  80 MHz clock, phase-locked to clk400 (5:1); also sampled as data in clk400 domain
- sync  in  1  clk80 domain, one-clk80-cycle frame marker; period ≥ 2 clk80 cycles
- trig_req  in  1  clk80 domain, request valid, sampled only at clk80 edges with sync=1
- trig_pos  in  4  clk80 domain, slot (clk400 cycles after frame start) of rising edge
- trig_width  in  4  clk80 domain, pulse length in clk400 cycles; 0 treated as 1
- trigger_out  out  1  clk400 registered, pad-ready trigger pulse
- dropped  out  1  clk80 registered, one-clk80-cycle pulse per discarded request

## Operation
- Capture (clk80): on posedge clk80 with sync=1: req80<=trig_req, pos80<=trig_pos, wid80<=trig_width. The values are held until the next sync edge. A frame without trig_req clears req80.
- Frame detect (clk400): sync1<=clk80; clear<=sync && clk80 && !sync1. This produces one pulse per frame, aligned to the rising clk80 edge of the sync cycle.
- Slot counter (4 bit): slot<=0 when clear=1, else slot<=slot+1, saturating at 15.
- Pending load: when slot==LOAD_SLOT: pend<=req80, pend_pos<=pos80, pend_wid<=wid80.
- Arm: when clear=1:
  - armed<=pend, pos_t<=pend_pos, wid_t<=(pend_wid==0 ? 1 : pend_wid).
  - pend<=0.
  - If armed was still 1 at that edge, the old request never fired: the block raises a drop event.
- States: IDLE, ARMED, PULSE.
  - ARMED→PULSE when slot==pos_t: trigger_out<=1, wcnt<=wid_t-1, armed<=0.
  - PULSE: trigger_out stays 1 while wcnt≠0, with wcnt decrementing each cycle. When wcnt==0, trigger_out<=0.
  - PULSE may extend across a clear.
- Collision: if an armed request reaches slot==pos_t while trigger_out=1, the request is discarded (armed<=0, drop event). The current pulse is unaffected.
- Unreachable position: pos_t ≥ frame length → request is still armed at the next clear → drop event.
- Drop crossing: each drop event toggles drop_tgl (clk400). clk80 synchronizes it with 2 flops plus an edge-detect register. dropped=1 for one clk80 cycle per toggle.
- Simultaneous drop sources in one clk400 cycle count as one event.
- Reset: async. All registers are 0, trigger_out=0 and dropped=0 immediately. Requests in flight are lost and never emitted.

## Timing
- Let E = the clk400 edge at which slot becomes 0 in frame n+1, where n is the frame whose sync captured the request.
- trigger_out rises at E+pos_t+1 clk400 cycles and stays high exactly max(trig_width,1) cycles.
- Request-to-pulse latency is one frame plus pos_t+1 clk400 cycles. Fine-position granularity is 2.5 ns.
- dropped appears 2–4 clk80 cycles after the clk400 drop event.
- At most one request per frame; maximum pulse length is 15 clk400 cycles.

## Test plan
- Sync every 2 clk80 (frame = 10 slots), trig_req=1, pos=0, width=1 → trigger_out high for exactly 1 clk400 cycle, rising 1 cycle after E; dropped stays 0.
- pos=9, width=4 → rise at E+10, high 4 cycles crossing the next clear; no further pulse without a new request.
- pos=12 (frame 10) → no pulse; dropped=1 for exactly one clk80 cycle about one frame later.
- Frame n: pos=9, width=15; frame n+1: pos=0 → first pulse full 15 cycles; second request dropped, one dropped pulse, trigger_out never re-rises.
- width=0, pos=3 → 1-cycle pulse at E+4; width=15 → 15-cycle pulse.
- Assert reset for 2 clk400 cycles in the middle of a width-8 pulse → trigger_out=0 during reset; after release, with no new sync request, no pulse and dropped=0.

Source files
------------

// File: rtl/trigger_out_async.sv
// Trigger transmitter: captures a trigger request in the clk80 domain and
// replays it as a single pulse on the output pad in the following sync frame.
// The pulse is placed at a fine position with clk400 resolution. Requests that
// cannot be emitted are reported back to clk80 as a one-cycle dropped pulse.
`timescale 1ps/1ps
module trigger_out_async #(
  parameter int unsigned LOAD_SLOT = 7
) (
  input  logic       clk400,
  input  logic       reset,
  input  logic       clk80,
  input  logic       sync,
  input  logic       trig_req,
  input  logic [3:0] trig_pos,
  input  logic [3:0] trig_width,
  output logic       trigger_out,
  output logic       dropped
);

  localparam logic [3:0] LOAD_SLOT_C = 4'(LOAD_SLOT);
  localparam logic [3:0] SLOT_MAX    = 4'd15;

  // clk80 domain
  logic       req80_q;
  logic [3:0] pos80_q;
  logic [3:0] wid80_q;
  logic [1:0] dsync_q;
  logic       dlast_q;
  logic       dropped_q;

  // clk400 domain
  logic       sync1_q;
  logic       clear_q;
  logic [3:0] slot_q;
  logic       pend_q;
  logic [3:0] pend_pos_q;
  logic [3:0] pend_wid_q;
  logic       armed_q,    armed_d;
  logic [3:0] pos_t_q,    pos_t_d;
  logic [3:0] wid_t_q,    wid_t_d;
  logic       trig_q,     trig_d;
  logic [3:0] wcnt_q,     wcnt_d;
  logic       drop_tgl_q, drop_tgl_d;

  logic       slot_hit;
  logic       drop_ev;

  // Capture the request at the sync edge; held until the next sync edge.
  always_ff @(posedge clk80 or posedge reset) begin
    if (reset) begin
      req80_q <= 1'b0;
      pos80_q <= 4'd0;
      wid80_q <= 4'd0;
    end else if (sync) begin
      req80_q <= trig_req;
      pos80_q <= trig_pos;
      wid80_q <= trig_width;
    end
  end

  // Bring the drop toggle into clk80 and turn each toggle into a one-cycle pulse.
  always_ff @(posedge clk80 or posedge reset) begin
    if (reset) begin
      dsync_q   <= 2'b00;
      dlast_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      dsync_q   <= {dsync_q[0], drop_tgl_q};
      dlast_q   <= dsync_q[1];
      dropped_q <= dsync_q[1] ^ dlast_q;
    end
  end

  // Frame start detect on the rising clk80 edge of the sync cycle, plus slot counter.
  always_ff @(posedge clk400 or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      clear_q <= 1'b0;
      slot_q  <= 4'd0;
    end else begin
      sync1_q <= clk80;
      clear_q <= sync && clk80 && !sync1_q;
      if (clear_q) begin
        slot_q <= 4'd0;
      end else if (slot_q != SLOT_MAX) begin
        slot_q <= slot_q + 4'd1;
      end
    end
  end

  // Move the clk80 request into clk400 mid-frame, when the clk80 copy is stable.
  always_ff @(posedge clk400 or posedge reset) begin
    if (reset) begin
      pend_q     <= 1'b0;
      pend_pos_q <= 4'd0;
      pend_wid_q <= 4'd0;
    end else if (clear_q) begin
      pend_q     <= 1'b0;
    end else if (slot_q == LOAD_SLOT_C) begin
      pend_q     <= req80_q;
      pend_pos_q <= pos80_q;
      pend_wid_q <= wid80_q;
    end
  end

  // Arm / fire / pulse-width control. Arming and pulsing overlap (a pulse may
  // run across the clear that arms the next request), so they are kept as two
  // flags rather than one exclusive state. A fire on the clear edge itself
  // counts as fired, not dropped.
  always_comb begin
    slot_hit   = armed_q && (slot_q == pos_t_q);
    drop_ev    = (slot_hit && trig_q) || (armed_q && clear_q && !slot_hit);
    drop_tgl_d = drop_tgl_q ^ drop_ev;

    if (clear_q) begin
      armed_d = pend_q;
      pos_t_d = pend_pos_q;
      wid_t_d = (pend_wid_q == 4'd0) ? 4'd1 : pend_wid_q;
    end else begin
      armed_d = slot_hit ? 1'b0 : armed_q;
      pos_t_d = pos_t_q;
      wid_t_d = wid_t_q;
    end

    if (slot_hit && !trig_q) begin
      trig_d = 1'b1;
      wcnt_d = wid_t_q - 4'd1;
    end else if (trig_q && (wcnt_q != 4'd0)) begin
      trig_d = 1'b1;
      wcnt_d = wcnt_q - 4'd1;
    end else begin
      trig_d = 1'b0;
      wcnt_d = wcnt_q;
    end
  end

  // Register the trigger control state; trigger_out comes straight from a flop.
  always_ff @(posedge clk400 or posedge reset) begin
    if (reset) begin
      armed_q    <= 1'b0;
      pos_t_q    <= 4'd0;
      wid_t_q    <= 4'd0;
      trig_q     <= 1'b0;
      wcnt_q     <= 4'd0;
      drop_tgl_q <= 1'b0;
    end else begin
      armed_q    <= armed_d;
      pos_t_q    <= pos_t_d;
      wid_t_q    <= wid_t_d;
      trig_q     <= trig_d;
      wcnt_q     <= wcnt_d;
      drop_tgl_q <= drop_tgl_d;
    end
  end

  assign trigger_out = trig_q;
  assign dropped     = dropped_q;

endmodule

// File: tb/tb_trigger_out_async.sv
// Directed bench for trigger_out_async: frames of 2 clk80 cycles (10 slots),
// expected pulses/drops queued when a request is issued, compared against the
// pulses and drop indications observed on the outputs.
`timescale 1ps/1ps
module tb_trigger_out_async;

  logic       clk400, clk80, reset, sync, trig_req;
  logic [3:0] trig_pos, trig_width;
  logic       trigger_out, dropped;

  typedef struct { int rise; int width; } pulse_t;

  int     cyc = 0;
  int     ph  = 0;
  int     tests = 0;
  int     fails = 0;
  int     last_end = -100;
  int     tot_drops = 0;
  pulse_t exp_pq[$];
  pulse_t obs_pq[$];
  int     exp_dq[$];
  int     obs_dq[$];
  int     drop_hi = 0;
  logic   mon_prev = 1'b0;
  int     mon_rise = 0;
  int     mon_w = 0;
  logic   drp_prev = 1'b0;
  int     pos_tab [5] = '{2, 7, 4, 0, 6};
  int     wid_tab [5] = '{3, 2, 6, 5, 1};

  trigger_out_async #(.LOAD_SLOT(7)) dut (
    .clk400      (clk400),
    .reset       (reset),
    .clk80       (clk80),
    .sync        (sync),
    .trig_req    (trig_req),
    .trig_pos    (trig_pos),
    .trig_width  (trig_width),
    .trigger_out (trigger_out),
    .dropped     (dropped)
  );

  // Phase-locked clocks: clk80 rising edges coincide with every 5th clk400 edge.
  initial begin
    clk400 = 1'b0;
    clk80  = 1'b0;
    forever begin
      #1250;
      ph = ph + 1;
      if (ph % 5 == 0) clk80 = ~clk80;
      if (clk400 == 1'b0) cyc = cyc + 1;
      clk400 = ~clk400;
    end
  end

  // Record each observed trigger pulse (rise cycle, width in clk400 cycles).
  always @(negedge clk400) begin
    if (trigger_out === 1'b1 && mon_prev !== 1'b1) begin
      mon_rise <= cyc;
      mon_w    <= 1;
    end else if (trigger_out === 1'b1) begin
      mon_w    <= mon_w + 1;
    end else if (mon_prev === 1'b1) begin
      obs_pq.push_back('{rise: mon_rise, width: mon_w});
    end
    mon_prev <= trigger_out;
  end

  // Record dropped rises and count every clk80 cycle it is high.
  always @(negedge clk80) begin
    if (dropped === 1'b1) drop_hi <= drop_hi + 1;
    if (dropped === 1'b1 && drp_prev !== 1'b1) obs_dq.push_back(cyc);
    drp_prev <= dropped;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    tests++;
    assert (obs >= lo && obs <= hi) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // One frame of 2 clk80 cycles; k is the clk400 cycle index of the capture edge.
  task automatic do_frame(input logic r, input logic [3:0] p, input logic [3:0] w, output int k);
    @(negedge clk80);
    sync = 1'b1; trig_req = r; trig_pos = p; trig_width = w;
    @(negedge clk80);
    k = cyc - 2;
    sync = 1'b0; trig_req = 1'b0; trig_pos = 4'd0; trig_width = 4'd0;
  endtask

  task automatic idle(input int n);
    int k;
    for (int i = 0; i < n; i++) do_frame(1'b0, 4'd0, 4'd0, k);
  endtask

  // Issue a request and queue its expected outcome: E = k+11, rise at E+pos+1.
  task automatic req(input int p, input int w);
    int k, r, wd;
    do_frame(1'b1, 4'(p), 4'(w), k);
    r  = k + 12 + p;
    wd = (w == 0) ? 1 : w;
    if (p >= 10) begin
      exp_dq.push_back(k + 21);
      tot_drops++;
    end else if (r <= last_end) begin
      exp_dq.push_back(r);
      tot_drops++;
    end else begin
      exp_pq.push_back('{rise: r, width: wd});
      last_end = r + wd;
    end
  endtask

  task automatic checkpoint(input string tag);
    pulse_t o, e;
    int     od, ed;
    check_int({tag, ".pulse_count"}, obs_pq.size(), exp_pq.size());
    while (obs_pq.size() > 0 && exp_pq.size() > 0) begin
      o = obs_pq.pop_front();
      e = exp_pq.pop_front();
      check_int({tag, ".pulse_rise"},  o.rise,  e.rise);
      check_int({tag, ".pulse_width"}, o.width, e.width);
    end
    obs_pq.delete();
    exp_pq.delete();
    check_int({tag, ".drop_count"}, obs_dq.size(), exp_dq.size());
    while (obs_dq.size() > 0 && exp_dq.size() > 0) begin
      od = obs_dq.pop_front();
      ed = exp_dq.pop_front();
      check_range({tag, ".drop_latency"}, od - ed, 12, 22);
    end
    obs_dq.delete();
    exp_dq.delete();
    check_int({tag, ".dropped_high_cycles"}, drop_hi, tot_drops);
  endtask

  initial begin
    int k, tmp, guard;
    reset = 1'b1; sync = 1'b0; trig_req = 1'b0; trig_pos = 4'd0; trig_width = 4'd0;
    repeat (3) @(negedge clk400);
    check_bit("reset.trigger_out", trigger_out, 1'b0);
    check_bit("reset.dropped", dropped, 1'b0);
    reset = 1'b0;
    idle(3);

    req(0, 1);  idle(3); checkpoint("pos0_w1");
    req(9, 4);  idle(3); checkpoint("pos9_w4");
    req(12, 1); idle(5); checkpoint("unreachable");
    req(9, 15); req(0, 1); idle(4); checkpoint("collision");
    req(3, 0);  idle(2); req(5, 15); idle(4); checkpoint("width_bounds");
    for (int i = 0; i < 5; i++) req(pos_tab[i], wid_tab[i]);
    idle(3); checkpoint("back_to_back");

    // Reset in the middle of a width-8 pulse at pos 2: high for 4 samples, then cut.
    do_frame(1'b1, 4'd2, 4'd8, k);
    exp_pq.push_back('{rise: k + 14, width: 4});
    do_frame(1'b0, 4'd0, 4'd0, tmp);
    guard = 0;
    while (cyc < k + 17 && guard < 40) begin
      @(negedge clk400);
      guard++;
    end
    #200 reset = 1'b1;
    #100 check_bit("mid_reset.trigger_out", trigger_out, 1'b0);
    check_bit("mid_reset.dropped", dropped, 1'b0);
    @(negedge clk400);
    check_bit("mid_reset2.trigger_out", trigger_out, 1'b0);
    @(negedge clk400);
    #200 reset = 1'b0;
    idle(4); checkpoint("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
